byte_link_responder: RTL and testbench
======================================

Name: byte_link_responder

Overview:
- Memory-side end of the 10-phase byte-serial CPU link.
- The CPU-side handler sends a 32-bit address and 32-bit write data one byte per phase over two 8-bit lanes, then a direction flag.
- After that it samples four read-data bytes on the bidirectional lane.
- This block deserialises each frame, issues one access to a single-cycle synchronous memory port, and serialises read data back onto the link.

Parameters:
- NBYTES, 4: bytes per address/data word; word width = 8*NBYTES. Frame length = 2*NBYTES+2 phases. Only 4 is verified.

Ports:
- clk  in  1  system clock, shared with the link.
- rst_n  in  1  asynchronous active-low reset.
- link_sync  in  1  high during phase 1 of every frame.
- link_addr_in  in  8  address lane: address byte k in phase k+1 (k=0..3, LSB first); phase 5 bit0 = write flag (1=write).
- link_data_in  in  8  write-data lane: write-data byte k in phase k+1.
- link_data_out  out  8  read-data byte driven in phases 6..9.
- link_data_oe  out  1  high only in phases 6..9 of read frames.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write qualifier, valid with mem_en.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data.
- mem_rdata  in  32  valid the cycle after mem_en with mem_we=0.
- frame_done  out  1  one-cycle pulse in phase 9 of each completed frame.
- sync_err  out  1  one-cycle pulse on an unexpected realignment.
- locked  out  1  high once the first link_sync is seen.

Behaviour:
- Reset (async assert, sync deassert): phase=0, locked=0, mem_addr=0, mem_wdata=0, rdata_q=0, is_read=0. All outputs are 0: link_data_out, link_data_oe, mem_en, mem_we, frame_done, sync_err.
- Phase counter 0..9 states:
  - IDLE/turnaround = 0.
  - ADDR0..ADDR3 = 1..4.
  - CTRL = 5.
  - RD0..RD3 = 6..9.
- Counter advances each clk and wraps 9 -> 0.
- link_sync high in any cycle: that cycle is phase 1 and the counter loads 2 for the next cycle.
- While locked=0: the counter holds 0 and the block ignores all lanes except link_sync. No mem_en, no oe.
- First link_sync sets locked=1 (registered) and starts the frame in that same cycle.
- Phases 1..4: on the edge ending phase k+1, capture link_addr_in into mem_addr byte k and link_data_in into mem_wdata byte k.
- Phase 5: mem_en=1 combinationally. mem_we=link_addr_in[0]. is_read is registered as ~link_addr_in[0]. mem_addr/mem_wdata are already stable.
- Read frames, phase 6:
  - link_data_out = mem_rdata[7:0] pass-through.
  - mem_rdata is captured into rdata_q at the end of phase 6.
- Read frames, phases 7..9: link_data_out = rdata_q byte (phase-6).
- Read frames: link_data_oe=1 for phases 6..9.
- Write frames: link_data_oe=0 and link_data_out=0 in phases 6..9. The host drives the lane.
- Outside phases 6..9: link_data_out=0 and oe=0. Phase 0 is the bus turnaround cycle.
- frame_done: combinational pulse when phase==9 and no link_sync in that cycle.
- Sync realignment:
  - link_sync seen while locked and phase is not 0 (normal arrival is after phase 0): sync_err pulses one cycle and the current frame is aborted.
  - If phase <5, no mem_en is issued for the aborted frame.
  - If phase >=6, the access already happened; oe drops immediately and there is no frame_done.
- link_sync during phase 5 of a frame: the new frame wins and no mem_en is issued in that cycle.
- Missing sync: the counter free-runs 9->0->1. Phase 1 proceeds without link_sync and does not count as an error.
- Reset mid-frame: immediate clear, locked=0, any in-flight access is abandoned. The memory may see a truncated mem_en only if reset asserts during phase 5.
- Latency: first address byte to mem_en = 4 cycles. mem_en to first read byte on link = 1 cycle.

Decomposition:
- Shared package link_pkg:
  - phase constants PH_IDLE=0, PH_ADDR0=1, PH_CTRL=5, PH_RD0=6, PH_LAST=9.
  - LINK_W=8.
  - CTRL_WRITE_BIT=0.
- The CPU-side handler imports the same package.
- One natural sub-module, link_phase_ctr: counter, lock and sync-error logic, exporting phase and locked.
- Byte capture and mux stay in the top.

Test Plan:
- Reset then sync, read frame: addr bytes 0x78,0x56,0x34,0x12, phase5 flag=0, memory model returns 0xCAFEBABE. Required: mem_en for exactly 1 cycle in phase 5 with mem_addr=0x12345678, mem_we=0; link_data_out BE,BA,FE,CA in phases 6..9 with oe=1; frame_done in phase 9.
- Write frame: addr 0x00000010, wdata 0xDEADBEEF, flag=1. Required: mem_en=mem_we=1 with mem_wdata=0xDEADBEEF; oe=0 for the whole frame; frame_done pulses.
- Back-to-back: 5 consecutive frames alternating read/write, sync every 10 cycles. Required: 5 frame_done pulses, no sync_err, correct bytes per frame.
- Early sync: sync again in phase 3 of a frame. Required: sync_err pulse, no mem_en for the aborted frame; the following frame completes normally.
- Before lock: drive lanes with random bytes and no sync for 30 cycles. Required: mem_en=0, oe=0, locked=0 throughout.
- Async reset during phase 7 of a read. Required: oe and link_data_out drop to 0 without waiting for clk; locked=0; the next sync relocks and completes a frame.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: phase numbering and lane constants shared by both ends of the byte-serial CPU link.
package link_pkg;
  localparam int LINK_W         = 8;
  localparam int NBYTES_DEF     = 4;
  localparam int CTRL_WRITE_BIT = 0;
  typedef logic [3:0] phase_t;
  localparam phase_t PH_IDLE  = 4'd0;
  localparam phase_t PH_ADDR0 = 4'd1;
  localparam phase_t PH_CTRL  = 4'd5;
  localparam phase_t PH_RD0   = 4'd6;
  localparam phase_t PH_LAST  = 4'd9;
endpackage

// File: rtl/link_phase_ctr.sv
// link_phase_ctr: frame phase counter with lock-on-first-sync and realignment error detection.
module link_phase_ctr
  import link_pkg::*;
#(
  parameter phase_t LAST = PH_LAST
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_sync,
  output phase_t o_phase,
  output logic   o_locked,
  output logic   o_sync_err
);
  phase_t r_phase;
  logic   r_locked;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_phase  <= PH_IDLE;
      r_locked <= 1'b0;
    end else begin
      r_locked <= r_locked | i_sync;
      r_phase  <= i_sync ? PH_ADDR0 + 4'd1 : !r_locked ? PH_IDLE : r_phase == LAST ? PH_IDLE : r_phase + 4'd1;
    end
  // a sync cycle is always phase 1, whatever the free-running count says
  assign o_phase    = i_sync ? PH_ADDR0 : r_phase;
  assign o_locked   = r_locked;
  // sync landing on the turnaround slot or its successor is a normal frame start
  assign o_sync_err = i_sync & r_locked & (r_phase != PH_IDLE) & (r_phase != PH_ADDR0);
endmodule

// File: rtl/byte_link_responder.sv
// byte_link_responder: memory-side end of the byte-serial link; deserialises a frame, issues
// one memory access and serialises read data back onto the bidirectional lane.
module byte_link_responder
  import link_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  link_sync,
  input  logic [LINK_W-1:0]     link_addr_in,
  input  logic [LINK_W-1:0]     link_data_in,
  output logic [LINK_W-1:0]     link_data_out,
  output logic                  link_data_oe,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [8*NBYTES-1:0]   mem_addr,
  output logic [8*NBYTES-1:0]   mem_wdata,
  input  logic [8*NBYTES-1:0]   mem_rdata,
  output logic                  frame_done,
  output logic                  sync_err,
  output logic                  locked
);
  localparam int     W      = 8 * NBYTES;
  localparam phase_t P_CTRL = phase_t'(NBYTES + 1);
  localparam phase_t P_RD0  = phase_t'(NBYTES + 2);
  localparam phase_t P_LAST = phase_t'(2 * NBYTES + 1);
  phase_t         w_phase;
  phase_t         w_rd_idx;
  logic           w_rd_win;
  logic           r_is_read;
  logic [W-1:0]   r_addr;
  logic [W-1:0]   r_wdata;
  logic [W-1:0]   r_rdata;
  logic [W-1:0]   w_rd_word;
  link_phase_ctr #(.LAST(P_LAST)) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sync     (link_sync),
    .o_phase    (w_phase),
    .o_locked   (locked),
    .o_sync_err (sync_err)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_is_read <= 1'b0;
    end else begin
      for (int k = 0; k < NBYTES; k++)
        if (w_phase == PH_ADDR0 + phase_t'(k)) begin
          r_addr[LINK_W*k +: LINK_W]  <= link_addr_in;
          r_wdata[LINK_W*k +: LINK_W] <= link_data_in;
        end
      if (mem_en) r_is_read <= ~link_addr_in[CTRL_WRITE_BIT];
      if (w_phase == P_RD0) r_rdata <= mem_rdata;
    end
  assign mem_en       = w_phase == P_CTRL;
  assign mem_we       = mem_en & link_addr_in[CTRL_WRITE_BIT];
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign w_rd_win     = w_phase >= P_RD0 && w_phase <= P_LAST;
  assign link_data_oe = r_is_read & w_rd_win;
  assign w_rd_idx     = w_phase - P_RD0;
  assign w_rd_word    = r_rdata >> {w_rd_idx, 3'b000};
  // first read byte bypasses the capture register so it reaches the lane one cycle after mem_en
  assign link_data_out = !link_data_oe ? '0 : w_phase == P_RD0 ? mem_rdata[LINK_W-1:0] : w_rd_word[LINK_W-1:0];
  assign frame_done    = w_phase == P_LAST;
endmodule

// File: tb/tb_byte_link_responder.sv
// tb_byte_link_responder: directed and random frames checked against a frame-level model of the link.
module tb_byte_link_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_sync = 1'b0;
  logic [7:0]  link_addr_in = '0;
  logic [7:0]  link_data_in = '0;
  logic [7:0]  link_data_out;
  logic        link_data_oe;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        frame_done;
  logic        sync_err;
  logic        locked;
  int          total = 0;
  int          bad = 0;
  bit          lk_model = 1'b0;
  logic        req_en = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wd = '0;
  logic [31:0] tb_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pool [4];

  byte_link_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link_sync     (link_sync),
    .link_addr_in  (link_addr_in),
    .link_data_in  (link_data_in),
    .link_data_out (link_data_out),
    .link_data_oe  (link_data_oe),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .frame_done    (frame_done),
    .sync_err      (sync_err),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // synchronous memory: request sampled mid-cycle, read data valid the cycle after
  always @(posedge clk)
    if (req_en) begin
      if (req_we) tb_mem[req_addr] = req_wd;
      else mem_rdata <= tb_mem.exists(req_addr) ? tb_mem[req_addr] : fill(req_addr);
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit s, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    link_sync = s;
    link_addr_in = a;
    link_data_in = d;
    #1;
    req_en = mem_en;
    req_we = mem_we;
    req_addr = mem_addr;
    req_wd = mem_wdata;
  endtask

  // runs phases 1..cut of a frame (cut=10 is a full frame including turnaround)
  task automatic frame(input logic [31:0] a, input logic [31:0] wd, input bit wr, input int cut, input bit exp_err);
    logic [31:0] rd;
    rd = ref_mem.exists(a) ? ref_mem[a] : fill(a);
    for (int p = 1; p <= cut; p++) begin
      int ph;
      logic [7:0] la, ld, exp_out;
      bit exp_oe;
      ph = p % 10;
      la = 8'($urandom);
      ld = 8'($urandom);
      if (ph >= 1 && ph <= 4) begin
        la = a[8*(ph-1) +: 8];
        ld = wd[8*(ph-1) +: 8];
      end
      if (ph == 5) la[0] = wr;
      cyc(p == 1, la, ld);
      exp_oe = !wr && ph >= 6;
      exp_out = '0;
      if (exp_oe) exp_out = rd[8*(ph-6) +: 8];
      chk($sformatf("ph%0d_status", ph), {58'd0, mem_en, mem_we, link_data_oe, frame_done, sync_err, locked},
          {58'd0, ph == 5, ph == 5 && wr, exp_oe, ph == 9, p == 1 && exp_err, p == 1 ? lk_model : 1'b1});
      chk($sformatf("ph%0d_data_out", ph), {56'd0, link_data_out}, {56'd0, exp_out});
      if (ph == 5) begin
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, a});
        if (wr) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, wd});
      end
      if (p == 1) lk_model = 1'b1;
    end
    if (wr && cut >= 5) ref_mem[a] = wd;
  endtask

  initial begin
    tb_mem[32'h1234_5678] = 32'hCAFE_BABE;
    ref_mem[32'h1234_5678] = 32'hCAFE_BABE;
    #2;
    chk("reset_outputs", {link_data_out, link_data_oe, mem_en, mem_we, frame_done, sync_err, locked, mem_addr, mem_wdata},
        '0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 8'($urandom), 8'($urandom));
      chk("prelock_status", {mem_en, link_data_oe, locked, link_data_out, frame_done, sync_err}, '0);
      chk("prelock_addr", {32'd0, mem_addr}, '0);
    end
    frame(32'h1234_5678, 32'h0BAD_F00D, 1'b0, 10, 1'b0);
    frame(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 10, 1'b0);
    frame(32'h0000_0010, 32'h0, 1'b0, 10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a, d;
      a = (i % 2 == 0) ? $urandom : a;
      d = $urandom;
      if (i % 2 == 0) frame(a, d, 1'b1, 10, 1'b0);
      else frame(pool[0], d, 1'b0, 10, 1'b0);
      if (i % 2 == 0) pool[0] = a;
    end
    frame(32'hAAAA_0001, 32'h1111_2222, 1'b1, 3, 1'b0);
    frame(32'h1234_5678, 32'h0, 1'b0, 10, 1'b1);
    frame(32'h0000_0010, 32'h0, 1'b0, 10, 1'b0);
    frame(32'hBBBB_0002, 32'h3333_4444, 1'b1, 4, 1'b0);
    frame(32'hCCCC_0003, 32'h5555_6666, 1'b1, 10, 1'b1);
    frame(32'hCCCC_0003, 32'h0, 1'b0, 7, 1'b0);
    frame(32'hCCCC_0003, 32'h0, 1'b0, 10, 1'b1);
    for (int i = 0; i < 4; i++) pool[i] = {$urandom_range(0, 255), 24'h00_0100} + 32'(i);
    for (int i = 0; i < 12; i++) frame(pool[$urandom_range(0, 3)], $urandom, 1'($urandom), 10, 1'b0);
    frame(32'h1234_5678, 32'h0, 1'b0, 7, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {link_data_oe, link_data_out, locked, mem_en}, '0);
    lk_model = 1'b0;
    #2 rst_n = 1'b1;
    frame(32'h1234_5678, 32'h0, 1'b0, 10, 1'b0);
    frame(32'h0000_0010, 32'h7777_8888, 1'b1, 10, 1'b0);
    frame(32'h0000_0010, 32'h0, 1'b0, 10, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
